dpram_hs_sync: RTL and testbench

- Parametrised single-clock dual-port RAM: one write port and one read port, each with a valid/ready handshake.
- The read side is pipelined and backpressure-safe; responses are never dropped, whatever rd_ready does.
- After reset, an internal sweep zero-fills the whole array, so contents are always defined.
- Serves as the generic buffer memory for datapath blocks running on a single clock.

---
 rtl/dpram_hs_sync.sv | 115 +++++++++++
 tb/tb_dpram_hs_sync.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dpram_hs_sync.sv
// dpram_hs_sync: single-clock dual-port RAM with handshaked write/read ports, zero-fill sweep and backpressure-safe read pipeline
module dpram_hs_sync #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int OUT_REG  = 1,
  parameter int RDW_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAT   = 1 + OUT_REG;
  localparam int CW    = $clog2(LAT + 2);
  localparam int IW    = $clog2(LAT + 1);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_sweep;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_run, w_wr, w_rd, w_pop, w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata, w_rdata;
  logic                r_s1_v, w_pv;
  logic [DATA_W-1:0]   r_s1_d, w_pd;
  logic [CW-1:0]       r_occ, r_cnt;
  logic [IW-1:0]       w_widx;
  logic [DATA_W-1:0]   r_buf [LAT+1];
  assign w_run        = (r_state == S_RUN);
  assign wr_ready     = w_run;
  assign init_done    = w_run;
  assign rd_req_ready = w_run && (r_occ < CW'(LAT + 1));
  assign w_wr         = wr_valid && w_run;
  assign w_rd         = rd_req_valid && rd_req_ready;
  assign rd_valid     = (r_cnt != '0);
  assign w_pop        = rd_valid && rd_ready;
  assign rd_data      = r_buf[0];
  assign w_we         = !w_run || w_wr;
  assign w_waddr      = w_run ? wr_addr : r_sweep;
  assign w_wdata      = w_run ? wr_data : '0;
  assign w_rdata      = (RDW_MODE != 0 && w_wr && wr_addr == rd_addr) ? wr_data : r_mem[rd_addr];
  assign w_widx       = IW'(r_cnt - CW'(w_pop));
  // Leave INIT once the sweep has written the last address
  always_comb begin
    w_state_nxt = (r_state == S_INIT && r_sweep == '1) ? S_RUN : r_state;
  end
  // State register and zero-fill sweep address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run) r_sweep <= r_sweep + 1'b1;
    end
  end
  // Array write: sweep zeros during INIT, user writes during RUN
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end
  // First read stage: array lookup with same-address collision handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1_d <= '0;
    end else begin
      r_s1_v <= w_rd;
      if (w_rd) r_s1_d <= w_rdata;
    end
  end
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              r_s2_v;
      logic [DATA_W-1:0] r_s2_d;
      // Optional second pipeline stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_v <= 1'b0;
          r_s2_d <= '0;
        end else begin
          r_s2_v <= r_s1_v;
          if (r_s1_v) r_s2_d <= r_s1_d;
        end
      end
      assign w_pv = r_s2_v;
      assign w_pd = r_s2_d;
    end else begin : g_noreg
      assign w_pv = r_s1_v;
      assign w_pd = r_s1_d;
    end
  endgenerate
  // Occupancy gate and response FIFO; head holds its value when the FIFO drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
      r_cnt <= '0;
      for (int i = 0; i <= LAT; i++) r_buf[i] <= '0;
    end else begin
      r_occ <= r_occ + CW'(w_rd) - CW'(w_pop);
      r_cnt <= r_cnt + CW'(w_pv) - CW'(w_pop);
      if (w_pop && r_cnt > CW'(1))
        for (int i = 0; i < LAT; i++) r_buf[i] <= r_buf[i+1];
      if (w_pv) r_buf[w_widx] <= w_pd;
    end
  end
endmodule

// File: tb/tb_dpram_hs_sync.sv
// tb_dpram_hs_sync: randomized scoreboard bench for dpram_hs_sync
module tb_dpram_hs_sync;
  localparam int DW = 8, AW = 4, DEPTH = 16, OUT_REG = 1, RDW = 1, LAT = 1 + OUT_REG;
  logic          clk = 0, rst = 1;
  logic          wr_valid = 0, rd_req_valid = 0, rd_ready = 1;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic          wr_ready, rd_req_ready, rd_valid, init_done;
  logic [DW-1:0] rd_data;
  int            vecs = 0, errs = 0;
  longint        cyc = 0;
  typedef struct { logic [DW-1:0] d; longint n; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] mmem [DEPTH];
  int            edges = 0, occ = 0;
  logic          m_run, m_rrdy, stall = 0;
  logic [DW-1:0] stall_d = 0;
  exp_t          e;

  dpram_hs_sync #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(OUT_REG), .RDW_MODE(RDW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .init_done(init_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents, readiness and expected responses
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      occ = 0;
      edges = 0;
      foreach (mmem[i]) mmem[i] = '0;
    end else begin
      m_run  = edges >= DEPTH;
      m_rrdy = m_run && occ < LAT + 1;
      chk("wr_ready", wr_ready, m_run);
      chk("rd_req_ready", rd_req_ready, m_rrdy);
      chk("init_done", init_done, m_run);
      if (rd_req_valid && m_rrdy) begin
        e.d = (RDW != 0 && wr_valid && wr_addr == rd_addr) ? wr_data : mmem[rd_addr];
        e.n = cyc;
        q.push_back(e);
      end
      occ += int'(rd_req_valid && m_rrdy) - int'(rd_valid && rd_ready);
      if (m_run && wr_valid) mmem[wr_addr] = wr_data;
      if (edges < DEPTH) edges++;
    end
  end

  // Monitor: order, data, exact latency and hold-under-backpressure
  always @(posedge clk or posedge rst) begin
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", rd_valid, 1);
        chk("hold_data", rd_data, stall_d);
      end
      if (rd_valid) begin
        if (q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL spurious_rd_valid: got rd_valid=1 data %0h expected no response (cycle %0d)", rd_data, cyc);
        end else begin
          chk("rd_not_early", cyc > q[0].n + LAT, 1);
          if (rd_ready) begin
            chk("rd_data", rd_data, q[0].d);
            void'(q.pop_front());
          end
        end
      end else if (q.size() != 0 && cyc > q[0].n + LAT) begin
        vecs++; errs++;
        $display("FAIL rd_late: got rd_valid=0 expected response accepted at cycle %0d (cycle %0d)", q[0].n, cyc);
      end
      stall = rd_valid && !rd_ready;
      stall_d = rd_data;
    end
  end

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic rr);
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_req_valid = rv; rd_addr = ra; rd_ready = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset_and_sweep();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rd_req_ready", rd_req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    @(negedge clk);
    rst = 0;
    wr_valid = 1; wr_addr = 5; wr_data = 8'hEE;
    rd_req_valid = 1; rd_addr = AW'($urandom); rd_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      chk("sweep_init_done", init_done, i == DEPTH - 1);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, 1, AW'(a), 1);
    idle(LAT + 2);
  endtask

  int acc;
  initial begin
    do_reset_and_sweep();
    read_all();
    // latency: write then read next cycle
    drive(1, 3, 8'hA5, 0, 0, 1);
    drive(0, 0, 0, 1, 3, 1);
    idle(LAT + 2);
    // streaming
    for (int a = 0; a < DEPTH; a++) drive(1, AW'(a), DW'(8'h10 + a), 0, 0, 1);
    read_all();
    // backpressure
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, AW'(i), 0);
      #1;
      if (rd_req_ready) acc++;
    end
    chk("bp_accepts", acc, LAT + 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, AW'(8 + i), 1);
    idle(LAT + 2);
    // collision
    drive(1, 7, 8'h33, 0, 0, 1);
    drive(1, 7, 8'h5A, 1, 7, 1);
    drive(0, 0, 0, 1, 7, 1);
    idle(LAT + 2);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom), ($urandom % 4) != 0);
    idle(LAT + 6);
    // reset mid-operation with responses buffered
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 2, 0);
    idle(0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_reset_buffered", rd_valid, 1);
    do_reset_and_sweep();
    read_all();
    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
